// File: rtl/enc_bundler_pkg.sv
// Shared encoder constants and the bundler FSM state type.
// Both the binders and the bundler use these definitions.
package enc_bundler_pkg;

  localparam int unsigned HV_DIM           = 16;
  localparam int unsigned FEATURES_PER_CC  = 8;
  localparam int unsigned NUM_CHUNKS       = 2;
  localparam int unsigned BUNDLE_CNT_W     = 4;
  localparam int unsigned BUNDLE_THRESHOLD = 3;
  localparam int unsigned SHIFTS           = FEATURES_PER_CC / 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    THRESH,
    DONE
  } bundle_state_t;

endpackage

// File: rtl/bundle_dim_counter.sv
// One hypervector dimension: lane popcount, saturating set-bit accumulator,
// and threshold compare.
module bundle_dim_counter #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned THRESHOLD = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             accum,
  input  logic [LANES-1:0] lane_bits,
  output logic             hit
);
  import enc_bundler_pkg::*;

  localparam int unsigned PC_W  = $clog2(LANES + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    pc = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      pc = pc + PC_W'(lane_bits[l]);
    end
    sum = SUM_W'(cnt_q) + SUM_W'(pc);
    // Carry into the extra bit means the count overflowed: clamp to all-ones.
    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (accum) begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q >= CNT_W'(THRESHOLD));

endmodule

// File: rtl/enc_bundler.sv
// Bundles NUM_CHUNKS beats of lane-bound HVs into a thresholded query HV.
// Holds the control FSM, beat counter and the query register.
module enc_bundler #(
  parameter int unsigned HV_DIM     = enc_bundler_pkg::HV_DIM,
  parameter int unsigned LANES      = enc_bundler_pkg::FEATURES_PER_CC / 2,
  parameter int unsigned NUM_CHUNKS = enc_bundler_pkg::NUM_CHUNKS,
  parameter int unsigned CNT_W      = enc_bundler_pkg::BUNDLE_CNT_W,
  parameter int unsigned THRESHOLD  = enc_bundler_pkg::BUNDLE_THRESHOLD
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_bundle,
  input  logic              in_valid,
  input  logic [HV_DIM-1:0] shifted_hv [0:LANES-1],
  output logic              busy,
  output logic              done,
  output logic [HV_DIM-1:0] query_hv
);
  import enc_bundler_pkg::*;

  localparam int unsigned BEAT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  bundle_state_t     state_q;
  bundle_state_t     state_d;
  logic [BEAT_W-1:0] beat_q;
  logic              clear;
  logic              accum;
  logic              last_beat;
  logic [HV_DIM-1:0] hit;

  assign last_beat = in_valid && (beat_q == BEAT_W'(NUM_CHUNKS - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_bundle) state_d = ACCUM;
      ACCUM:  if (last_beat)    state_d = THRESH;
      THRESH: state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    clear = (state_q == IDLE) && start_bundle;
    accum = (state_q == ACCUM) && in_valid;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      beat_q <= '0;
    end else if (clear) begin
      beat_q <= '0;
    end else if (accum) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      query_hv <= '0;
    end else if (state_q == THRESH) begin
      query_hv <= hit;
    end
  end

  for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
    logic [LANES-1:0] lane_bits;

    always_comb begin
      lane_bits = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        lane_bits[l] = shifted_hv[l][d];
      end
    end

    bundle_dim_counter #(
      .LANES     (LANES),
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD)
    ) u_cnt (
      .clk       (clk),
      .nrst      (nrst),
      .clear     (clear),
      .accum     (accum),
      .lane_bits (lane_bits),
      .hit       (hit[d])
    );
  end

endmodule

// File: tb/tb_enc_bundler.sv
// Directed self-checking bench for enc_bundler: main instance plus a
// narrow-counter instance for saturation.
module tb_enc_bundler;

  logic        clk;
  logic        nrst;

  logic        start_a, valid_a, busy_a, done_a;
  logic [15:0] hv_a [0:3];
  logic [15:0] q_a;

  logic        start_s, valid_s, busy_s, done_s;
  logic [15:0] hv_s [0:3];
  logic [15:0] q_s;

  int checks;
  int failures;
  int done_pulses;
  int p0;

  enc_bundler #(
    .HV_DIM     (16),
    .LANES      (4),
    .NUM_CHUNKS (2),
    .CNT_W      (4),
    .THRESHOLD  (3)
  ) u_dut (
    .clk          (clk),
    .nrst         (nrst),
    .start_bundle (start_a),
    .in_valid     (valid_a),
    .shifted_hv   (hv_a),
    .busy         (busy_a),
    .done         (done_a),
    .query_hv     (q_a)
  );

  enc_bundler #(
    .HV_DIM     (16),
    .LANES      (4),
    .NUM_CHUNKS (3),
    .CNT_W      (3),
    .THRESHOLD  (3)
  ) u_sat (
    .clk          (clk),
    .nrst         (nrst),
    .start_bundle (start_s),
    .in_valid     (valid_s),
    .shifted_hv   (hv_s),
    .busy         (busy_s),
    .done         (done_s),
    .query_hv     (q_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done_a) done_pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_hv(input bit sel, input logic [15:0] a0, a1, a2, a3);
    if (!sel) begin
      hv_a[0] = a0; hv_a[1] = a1; hv_a[2] = a2; hv_a[3] = a3;
    end else begin
      hv_s[0] = a0; hv_s[1] = a1; hv_s[2] = a2; hv_s[3] = a3;
    end
  endtask

  task automatic do_start(input bit sel);
    if (!sel) start_a = 1'b1; else start_s = 1'b1;
    step();
    start_a = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic beat(input bit sel, input logic [15:0] a0, a1, a2, a3);
    set_hv(sel, a0, a1, a2, a3);
    if (!sel) valid_a = 1'b1; else valid_s = 1'b1;
    step();
    valid_a = 1'b0;
    valid_s = 1'b0;
    set_hv(sel, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
  endtask

  // Called right after the last beat's edge: state is THRESH.
  task automatic finish_run(input bit sel, input string tag, input logic [15:0] exp);
    chk({tag, "_thresh_done"}, sel ? done_s : done_a, 1'b0);
    chk({tag, "_thresh_busy"}, sel ? busy_s : busy_a, 1'b1);
    step();
    chk({tag, "_done"},  sel ? done_s : done_a, 1'b1);
    chk({tag, "_query"}, sel ? q_s : q_a, exp);
    step();
    chk({tag, "_idle_busy"}, sel ? busy_s : busy_a, 1'b0);
    chk({tag, "_idle_done"}, sel ? done_s : done_a, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    done_pulses = 0;
    nrst = 1'b0;
    start_a = 1'b0; valid_a = 1'b0;
    start_s = 1'b0; valid_s = 1'b0;
    set_hv(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    set_hv(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step();
    step();
    chk("rst_busy",  busy_a, 1'b0);
    chk("rst_done",  done_a, 1'b0);
    chk("rst_query", q_a, 16'h0000);
    chk("rst_sat_busy", busy_s, 1'b0);
    nrst = 1'b1;
    step();

    // Basic: counts 8,8,4,4 on bits 0..3
    do_start(0);
    chk("basic_busy", busy_a, 1'b1);
    beat(0, 16'h000F, 16'h000F, 16'h000F, 16'h000F);
    beat(0, 16'h0003, 16'h0003, 16'h0003, 16'h0003);
    finish_run(0, "basic", 16'h000F);

    // Threshold edge: bit0 count 3 set, bit1 count 1 clear
    do_start(0);
    beat(0, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
    beat(0, 16'h0001, 16'h0002, 16'h0000, 16'h0000);
    finish_run(0, "thr", 16'h0001);

    // Gapped valid, ignored IDLE beats and an extra start while busy
    p0 = done_pulses;
    set_hv(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    valid_a = 1'b1;
    step();
    step();
    chk("gap_idle_busy", busy_a, 1'b0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    valid_a = 1'b0;
    chk("gap_start_busy", busy_a, 1'b1);
    beat(0, 16'h000F, 16'h000F, 16'h000F, 16'h000F);
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    chk("gap_hold_query", q_a, 16'h0001);
    chk("gap_accum_busy", busy_a, 1'b1);
    beat(0, 16'h0003, 16'h0003, 16'h0003, 16'h0003);
    finish_run(0, "gap", 16'h000F);
    step();
    chk("gap_one_done", done_pulses - p0, 1);

    // Reset in the middle of ACCUM
    do_start(0);
    beat(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    nrst = 1'b0;
    #1;
    chk("mrst_busy",  busy_a, 1'b0);
    chk("mrst_done",  done_a, 1'b0);
    chk("mrst_query", q_a, 16'h0000);
    step();
    nrst = 1'b1;
    step();
    do_start(0);
    beat(0, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
    beat(0, 16'h0001, 16'h0002, 16'h0000, 16'h0000);
    finish_run(0, "mrst_rerun", 16'h0001);

    // Back-to-back: start right after DONE, old query held until THRESH
    do_start(0);
    beat(0, 16'h000F, 16'h000F, 16'h000F, 16'h000F);
    beat(0, 16'h0003, 16'h0003, 16'h0003, 16'h0003);
    finish_run(0, "b2b_first", 16'h000F);
    do_start(0);
    chk("b2b_busy", busy_a, 1'b1);
    chk("b2b_hold_start", q_a, 16'h000F);
    beat(0, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
    beat(0, 16'h0001, 16'h0002, 16'h0000, 16'h0000);
    chk("b2b_hold_thresh", q_a, 16'h000F);
    finish_run(0, "b2b_second", 16'h0001);

    // Saturation, 3-bit counters: 4, 8->7, 12->7
    do_start(1);
    beat(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    beat(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    beat(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    finish_run(1, "sat", 16'hFFFF);
    // Clamped 4,7,7 stays set; a wrapping counter would read 4,0,0
    do_start(1);
    beat(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    beat(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    beat(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    finish_run(1, "sat_nowrap", 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
